// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the UDLX data-memory responder.
package dlx_mem_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam int unsigned DEF_ADDR_WIDTH  = 10;
   localparam int unsigned DEF_WAIT_CYCLES = 2;
   localparam int unsigned WAIT_CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

endpackage

// File: rtl/dlx_sp_ram.sv
// Single-port synchronous RAM: one write port, registered read (read-old on collision).
module dlx_sp_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dlx_data_mem_resp.sv
// Data-memory responder: one access at a time with WAIT_CYCLES wait states.
// Optional boot-load port enabled by defining DATA_MEM_BOOT_EN.
module dlx_data_mem_resp
   import dlx_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int unsigned DATA_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned WAIT_CYCLES     = DEF_WAIT_CYCLES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       data_rd_en,
   input  logic                       data_wr_en,
   input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0]      data_write,
   output logic [DATA_WIDTH-1:0]      data_read,
   output logic                       data_valid,
   output logic                       data_wr_ack,
   output logic                       data_stall,
   output logic                       data_err
`ifdef DATA_MEM_BOOT_EN
   ,
   input  logic                       boot_mode,
   input  logic                       boot_wr_en,
   input  logic [DATA_ADDR_WIDTH-1:0] boot_addr,
   input  logic [DATA_WIDTH-1:0]      boot_data
`endif
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
   localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

   mem_state_t                 state_q, state_d;
   logic [WAIT_CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]      wdata_q;
   logic                       rd_q, wr_q;
   logic [DATA_WIDTH-1:0]      read_q;
   logic                       accept;
   logic                       boot_active, boot_we;
   logic [DATA_ADDR_WIDTH-1:0] boot_a;
   logic [DATA_WIDTH-1:0]      boot_d;
   logic                       ram_we;
   logic [DATA_ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0]      ram_wdata, ram_rdata;
   logic [DATA_WIDTH-1:0]      resp_word;

`ifdef DATA_MEM_BOOT_EN
   // Boot only takes the array while idle; an in-flight access finishes first.
   assign boot_active = boot_mode && (state_q == IDLE);
   assign boot_we     = boot_active && boot_wr_en;
   assign boot_a      = boot_addr;
   assign boot_d      = boot_data;
`else
   assign boot_active = 1'b0;
   assign boot_we     = 1'b0;
   assign boot_a      = '0;
   assign boot_d      = '0;
`endif

   assign accept = (state_q == IDLE) && !boot_active && (data_rd_en || data_wr_en);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = WAIT_LOAD;
               state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         read_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= data_addr;
            wdata_q <= data_write;
            rd_q    <= data_rd_en;
            wr_q    <= data_wr_en;
         end
         if (state_q == RESP && rd_q) read_q <= resp_word;
      end
   end

   // The read is launched at the accept edge from the live address so data is
   // ready in RESP even with zero wait states; the write lands at the end of RESP.
   assign ram_we    = boot_we || (state_q == RESP && wr_q);
   assign ram_addr  = boot_we ? boot_a : ((state_q == IDLE) ? data_addr : addr_q);
   assign ram_wdata = boot_we ? boot_d : wdata_q;

   dlx_sp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DATA_ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Combined rd+wr returns the store data (write-first).
   assign resp_word   = wr_q ? wdata_q : ram_rdata;

   assign data_valid  = (state_q == RESP) && rd_q;
   assign data_wr_ack = (state_q == RESP) && wr_q;
   assign data_read   = data_valid ? resp_word : read_q;
   assign data_err    = accept && data_rd_en && data_wr_en;
   assign data_stall  = (state_q != IDLE) || boot_active;

endmodule

// File: tb/tb_dlx_data_mem_resp.sv
// Directed self-checking bench for dlx_data_mem_resp (WAIT_CYCLES=2 and 0 instances).
module tb_dlx_data_mem_resp;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        rd_en2 = 1'b0, wr_en2 = 1'b0;
   logic [9:0]  addr2  = '0;
   logic [31:0] wdata2 = '0;
   logic [31:0] rdata2;
   logic        valid2, ack2, stall2, err2;

   logic        rd_en0 = 1'b0, wr_en0 = 1'b0;
   logic [9:0]  addr0  = '0;
   logic [31:0] wdata0 = '0;
   logic [31:0] rdata0;
   logic        valid0, ack0, stall0, err0;

`ifdef DATA_MEM_BOOT_EN
   logic        boot_mode = 1'b0, boot_wr_en = 1'b0;
   logic [9:0]  boot_addr = '0;
   logic [31:0] boot_data = '0;
   logic        boot_off = 1'b0;
   logic [9:0]  boot_off_a = '0;
   logic [31:0] boot_off_d = '0;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   dlx_data_mem_resp #(
      .DATA_WIDTH      (32),
      .DATA_ADDR_WIDTH (10),
      .WAIT_CYCLES     (2)
   ) dut2 (
      .clk         (clk),
      .rst         (rst),
      .data_rd_en  (rd_en2),
      .data_wr_en  (wr_en2),
      .data_addr   (addr2),
      .data_write  (wdata2),
      .data_read   (rdata2),
      .data_valid  (valid2),
      .data_wr_ack (ack2),
      .data_stall  (stall2),
      .data_err    (err2)
`ifdef DATA_MEM_BOOT_EN
      ,
      .boot_mode   (boot_mode),
      .boot_wr_en  (boot_wr_en),
      .boot_addr   (boot_addr),
      .boot_data   (boot_data)
`endif
   );

   dlx_data_mem_resp #(
      .DATA_WIDTH      (32),
      .DATA_ADDR_WIDTH (10),
      .WAIT_CYCLES     (0)
   ) dut0 (
      .clk         (clk),
      .rst         (rst),
      .data_rd_en  (rd_en0),
      .data_wr_en  (wr_en0),
      .data_addr   (addr0),
      .data_write  (wdata0),
      .data_read   (rdata0),
      .data_valid  (valid0),
      .data_wr_ack (ack0),
      .data_stall  (stall0),
      .data_err    (err0)
`ifdef DATA_MEM_BOOT_EN
      ,
      .boot_mode   (boot_off),
      .boot_wr_en  (boot_off),
      .boot_addr   (boot_off_a),
      .boot_data   (boot_off_d)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One access on the WAIT_CYCLES=2 instance; checks every cycle through RESP+1.
   task automatic acc2(input logic rd, input logic wr, input logic [9:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
      @(posedge clk); #1;
      rd_en2 = rd; wr_en2 = wr; addr2 = a; wdata2 = d;
      @(negedge clk);
      check({tag, "_stall_acc"}, 32'(stall2), 32'(0));
      check({tag, "_err_acc"}, 32'(err2), 32'(rd & wr));
      @(posedge clk); #1;
      rd_en2 = 1'b0; wr_en2 = 1'b0;
      for (int unsigned c = 1; c <= 3; c++) begin
         @(negedge clk);
         check({tag, "_stall"}, 32'(stall2), 32'(1));
         check({tag, "_valid"}, 32'(valid2), 32'((c == 3) && rd));
         check({tag, "_ack"}, 32'(ack2), 32'((c == 3) && wr));
         check({tag, "_err"}, 32'(err2), 32'(0));
         if (c == 3 && rd) check({tag, "_rdata"}, rdata2, exp_rd);
      end
      @(negedge clk);
      check({tag, "_stall_end"}, 32'(stall2), 32'(0));
      check({tag, "_valid_end"}, 32'(valid2), 32'(0));
      check({tag, "_ack_end"}, 32'(ack2), 32'(0));
      if (rd) check({tag, "_rdata_hold"}, rdata2, exp_rd);
   endtask

   task automatic store0(input logic [9:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      wr_en0 = 1'b1; addr0 = a; wdata0 = d;
      @(posedge clk); #1;
      wr_en0 = 1'b0;
      @(negedge clk);
      check("w0_store_ack", 32'(ack0), 32'(1));
      check("w0_store_stall", 32'(stall0), 32'(1));
      @(negedge clk);
      check("w0_store_ack_end", 32'(ack0), 32'(0));
      check("w0_store_stall_end", 32'(stall0), 32'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      #12;
      check("rst_rdata2", rdata2, 32'h0);
      check("rst_valid2", 32'(valid2), 32'(0));
      check("rst_ack2", 32'(ack2), 32'(0));
      check("rst_stall2", 32'(stall2), 32'(0));
      check("rst_err2", 32'(err2), 32'(0));
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_stall0", 32'(stall0), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      // WAIT_CYCLES=2 store then load
      acc2(1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 32'h0, "st010");
      acc2(1'b1, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, "ld010");
      acc2(1'b0, 1'b1, 10'h000, 32'h5A5AA5A5, 32'h0, "st000");
      acc2(1'b1, 1'b0, 10'h000, 32'h0, 32'h5A5AA5A5, "ld000");
      check("ld010_still", rdata2, 32'h5A5AA5A5);
      acc2(1'b1, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, "ld010b");

      // simultaneous rd+wr at top address
      acc2(1'b1, 1'b1, 10'h3FF, 32'h12345678, 32'h12345678, "both3ff");
      acc2(1'b1, 1'b0, 10'h3FF, 32'h0, 32'h12345678, "ld3ff");

      // WAIT_CYCLES=0: back-to-back loads, second held through stall
      store0(10'h001, 32'h11111111);
      store0(10'h002, 32'h22222222);
      @(posedge clk); #1;
      rd_en0 = 1'b1; addr0 = 10'h001;
      @(negedge clk);
      check("w0_acc1_stall", 32'(stall0), 32'(0));
      @(posedge clk); #1;
      addr0 = 10'h002;
      @(negedge clk);
      check("w0_resp1_valid", 32'(valid0), 32'(1));
      check("w0_resp1_data", rdata0, 32'h11111111);
      check("w0_resp1_stall", 32'(stall0), 32'(1));
      @(negedge clk);
      check("w0_gap_valid", 32'(valid0), 32'(0));
      check("w0_gap_stall", 32'(stall0), 32'(0));
      check("w0_gap_hold", rdata0, 32'h11111111);
      @(posedge clk); #1;
      rd_en0 = 1'b0;
      @(negedge clk);
      check("w0_resp2_valid", 32'(valid0), 32'(1));
      check("w0_resp2_data", rdata0, 32'h22222222);
      @(negedge clk);
      check("w0_idle_valid", 32'(valid0), 32'(0));
      check("w0_idle_hold", rdata0, 32'h22222222);

      // reset during WAIT aborts the store
      acc2(1'b0, 1'b1, 10'h020, 32'hAAAA5555, 32'h0, "st020");
      @(posedge clk); #1;
      wr_en2 = 1'b1; addr2 = 10'h020; wdata2 = 32'h0BADF00D;
      @(posedge clk); #1;
      wr_en2 = 1'b0;
      @(negedge clk);
      check("abort_wait_stall", 32'(stall2), 32'(1));
      #1 rst = 1'b1;
      #1;
      check("abort_stall", 32'(stall2), 32'(0));
      check("abort_ack", 32'(ack2), 32'(0));
      check("abort_valid", 32'(valid2), 32'(0));
      check("abort_rdata", rdata2, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("abort_ack_hold", 32'(ack2), 32'(0));
      rst = 1'b0;
      acc2(1'b1, 1'b0, 10'h020, 32'h0, 32'hAAAA5555, "ld020");

`ifdef DATA_MEM_BOOT_EN
      // boot write while the core requests the same word
      @(posedge clk); #1;
      boot_mode = 1'b1; boot_wr_en = 1'b1; boot_addr = 10'h005; boot_data = 32'hCAFEF00D;
      rd_en2 = 1'b1; addr2 = 10'h005;
      @(negedge clk);
      check("boot_stall", 32'(stall2), 32'(1));
      check("boot_err", 32'(err2), 32'(0));
      @(posedge clk); #1;
      boot_wr_en = 1'b0;
      for (int unsigned c = 0; c < 4; c++) begin
         @(negedge clk);
         check("boot_hold_stall", 32'(stall2), 32'(1));
         check("boot_hold_valid", 32'(valid2), 32'(0));
      end
      @(posedge clk); #1;
      boot_mode = 1'b0; rd_en2 = 1'b0;
      @(negedge clk);
      check("boot_release_stall", 32'(stall2), 32'(0));
      acc2(1'b1, 1'b0, 10'h005, 32'h0, 32'hCAFEF00D, "ld005");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
